// File: rtl/adc_capture_seq_pkg.sv
// Shared types and selection helpers for the ADC calibration capture sequencer.
package adc_capture_seq_pkg;

  localparam int unsigned C_NUM_SEL  = 4;
  localparam int unsigned C_SEL_BITS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_NEXT,
    S_FINISH
  } t_seq_state;

  typedef struct packed {
    logic                  found;
    logic [C_SEL_BITS-1:0] idx;
  } t_sel_res;

  // Lowest set mask bit strictly above cur.
  function automatic t_sel_res next_sel(input logic [C_NUM_SEL-1:0]  mask,
                                        input logic [C_SEL_BITS-1:0] cur);
    t_sel_res res;
    res = '0;
    for (int unsigned k = 0; k < C_NUM_SEL; k++) begin
      if (!res.found && (k > 32'(cur)) && mask[k[C_SEL_BITS-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[C_SEL_BITS-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [C_SEL_BITS-1:0] first_sel(input logic [C_NUM_SEL-1:0] mask);
    logic [C_SEL_BITS-1:0] idx;
    logic                  found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < C_NUM_SEL; k++) begin
      if (!found && mask[k[C_SEL_BITS-1:0]]) begin
        found = 1'b1;
        idx   = k[C_SEL_BITS-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_capture_seq_timer.sv
// Loadable down-counter; stops at zero. Used for settle timing and decimation phase.
module adc_capture_seq_timer #(
  parameter int unsigned G_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [G_WIDTH-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [G_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - G_WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/adc_capture_seq.sv
// Sweeps enabled calibrator selections, settles, and streams ADC samples into adc_meas RAM.
// Optional decimation (decim_i) is enabled by defining ADC_CAPTURE_SEQ_DECIM_EN.
module adc_capture_seq
  import adc_capture_seq_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH  = 32,
  parameter int unsigned G_REGION_BITS = 10,
  parameter int unsigned G_SETTLE      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [C_NUM_SEL-1:0]      sel_mask_i,
  input  logic [G_REGION_BITS:0]    nsamp_i,
`ifdef ADC_CAPTURE_SEQ_DECIM_EN
  input  logic [3:0]                decim_i,
`endif
  input  logic                      adc_valid_i,
  input  logic [G_DATA_WIDTH-1:0]   adc_data_i,
  output logic [C_SEL_BITS-1:0]     cal_sel_o,
  output logic [G_REGION_BITS+1:0]  ram_adr_o,
  output logic                      ram_we_o,
  output logic [G_DATA_WIDTH-1:0]   ram_dat_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o
);

  localparam int unsigned C_SW = (G_SETTLE > 1) ? $clog2(G_SETTLE) : 1;
  localparam logic [C_SW-1:0] C_SETTLE_LOAD = C_SW'(G_SETTLE - 1);
  localparam logic [G_REGION_BITS:0] C_CNT_ONE = (G_REGION_BITS+1)'(1);

  t_seq_state                  r_state, w_state_nxt;
  logic [C_NUM_SEL-1:0]        r_mask;
  logic [G_REGION_BITS:0]      r_nsamp;
  logic [G_REGION_BITS:0]      r_cnt;
  logic [C_SEL_BITS-1:0]       r_sel, w_sel_nxt;
  logic                        r_we, w_we_nxt;
  logic [G_REGION_BITS+1:0]    r_adr;
  logic [G_DATA_WIDTH-1:0]     r_dat;
  logic                        r_busy, w_busy_nxt;
  logic                        r_done, w_done_nxt;
  logic                        r_aborted, w_aborted_nxt;
  logic                        w_latch, w_cnt_clr, w_accept;
  logic                        w_settle_load, w_settle_dec, w_settle_zero;
  logic                        w_take;
  t_sel_res                    w_next;

  adc_capture_seq_timer #(.G_WIDTH(C_SW)) u_settle_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_settle_load),
    .i_load_val (C_SETTLE_LOAD),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

`ifdef ADC_CAPTURE_SEQ_DECIM_EN
  logic [3:0] r_decim;
  logic       w_phase_load, w_phase_dec, w_phase_zero, w_cap_valid;
  logic [3:0] w_phase_val;

  // Phase restarts at zero on every settle so the first post-settle sample is kept.
  assign w_cap_valid  = (r_state == S_CAPTURE) && adc_valid_i;
  assign w_phase_load = w_settle_load || (w_cap_valid && w_phase_zero);
  assign w_phase_val  = w_settle_load ? 4'd0 : r_decim;
  assign w_phase_dec  = w_cap_valid && !w_phase_zero;
  assign w_take       = w_phase_zero;

  adc_capture_seq_timer #(.G_WIDTH(4)) u_phase_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_phase_load),
    .i_load_val (w_phase_val),
    .i_dec      (w_phase_dec),
    .o_zero     (w_phase_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_decim <= '0;
    end else if (w_latch) begin
      r_decim <= decim_i;
    end
  end
`else
  assign w_take = 1'b1;
`endif

  assign w_next = next_sel(r_mask, r_sel);

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = r_aborted;
    w_we_nxt      = 1'b0;
    w_latch       = 1'b0;
    w_cnt_clr     = 1'b0;
    w_accept      = 1'b0;
    w_settle_load = 1'b0;
    w_settle_dec  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_latch       = 1'b1;
          w_aborted_nxt = 1'b0;
          if ((sel_mask_i == '0) || (nsamp_i == '0)) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
          end else begin
            w_sel_nxt     = first_sel(sel_mask_i);
            w_busy_nxt    = 1'b1;
            w_settle_load = 1'b1;
            w_state_nxt   = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (w_settle_zero) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_settle_dec = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (adc_valid_i && w_take) begin
          w_we_nxt = 1'b1;
          w_accept = 1'b1;
          if ((r_cnt + C_CNT_ONE) == r_nsamp) begin
            w_state_nxt = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (w_next.found) begin
          w_sel_nxt     = w_next.idx;
          w_settle_load = 1'b1;
          w_state_nxt   = S_SETTLE;
        end else begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Abort overrides everything; a write already on the port completes at this edge.
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b1;
      w_we_nxt      = 1'b0;
      w_accept      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_nsamp   <= '0;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_we      <= w_we_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      if (w_latch) begin
        r_mask  <= sel_mask_i;
        r_nsamp <= nsamp_i;
      end
      if (w_we_nxt) begin
        r_adr <= {r_sel, r_cnt[G_REGION_BITS-1:0]};
        r_dat <= adc_data_i;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign cal_sel_o = r_sel;
  assign ram_adr_o = r_adr;
  assign ram_we_o  = r_we;
  assign ram_dat_o = r_dat;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign aborted_o = r_aborted;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Self-checking bench for adc_capture_seq: transaction-level reference model plus directed runs.
module tb_adc_capture_seq;

  localparam int DW = 32;
  localparam int RB = 10;
  localparam int ST = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [3:0]    mask = '0;
  logic [RB:0]   nsamp = '0;
  logic [3:0]    decim = '0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [1:0]    cal_sel;
  logic [RB+1:0] adr;
  logic          we;
  logic [DW-1:0] dat;
  logic          busy, done, aborted;

  always #5 clk = ~clk;

  adc_capture_seq #(
    .G_DATA_WIDTH  (DW),
    .G_REGION_BITS (RB),
    .G_SETTLE      (ST)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .sel_mask_i  (mask),
    .nsamp_i     (nsamp),
`ifdef ADC_CAPTURE_SEQ_DECIM_EN
    .decim_i     (decim),
`endif
    .adc_valid_i (valid),
    .adc_data_i  (data),
    .cal_sel_o   (cal_sel),
    .ram_adr_o   (adr),
    .ram_we_o    (we),
    .ram_dat_o   (dat),
    .busy_o      (busy),
    .done_o      (done),
    .aborted_o   (aborted)
  );

  int nchk = 0;
  int nerr = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a run is a list of selections; each selection ignores samples for
  // ST edges after cal_sel changes, then takes nsamp samples; one gap edge between
  // selections, then a one-cycle done.
  bit   m_run = 0, m_fin = 0, m_next = 0;
  int   m_age = 0, m_pos = 0, m_nsel = 0, m_taken = 0, m_skip = 0, m_nsamp = 0, m_decim = 0;
  int   m_list[4];
  logic          e_we = 0, e_busy = 0, e_done = 0, e_ab = 0;
  logic [1:0]    e_sel = '0;
  logic [RB+1:0] e_adr = '0;
  logic [DW-1:0] e_dat = '0;

  function automatic void model_reset();
    m_run = 0; m_fin = 0; m_next = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_ab = 0;
    e_sel = '0; e_adr = '0; e_dat = '0;
  endfunction

  function automatic void model_step();
    e_we   = 1'b0;
    e_done = 1'b0;
    if (!m_run && !m_fin) begin
      if (start && !abort) begin
        e_ab   = 1'b0;
        m_nsel = 0;
        for (int k = 0; k < 4; k++) if (mask[k]) begin m_list[m_nsel] = k; m_nsel++; end
        m_nsamp = int'(nsamp);
`ifdef ADC_CAPTURE_SEQ_DECIM_EN
        m_decim = int'(decim);
`else
        m_decim = 0;
`endif
        if (m_nsel == 0 || m_nsamp == 0) begin
          m_fin = 1; e_done = 1'b1;
        end else begin
          m_run = 1; m_pos = 0; e_sel = 2'(m_list[0]); e_busy = 1'b1;
          m_age = 0; m_taken = 0; m_skip = 0; m_next = 0;
        end
      end
    end else if (abort) begin
      m_run = 0; m_fin = 0; m_next = 0; e_busy = 1'b0; e_ab = 1'b1;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_next) begin
      m_next = 0;
      if (m_pos + 1 < m_nsel) begin
        m_pos++; e_sel = 2'(m_list[m_pos]);
        m_age = 0; m_taken = 0; m_skip = 0;
      end else begin
        m_run = 0; m_fin = 1; e_done = 1'b1; e_busy = 1'b0;
      end
    end else begin
      m_age++;
      if (m_age > ST && valid) begin
        if (m_skip == 0) begin
          e_we  = 1'b1;
          e_adr = {e_sel, m_taken[RB-1:0]};
          e_dat = data;
          m_taken++;
          m_skip = m_decim;
          if (m_taken == m_nsamp) m_next = 1;
        end else begin
          m_skip--;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy_o",    32'(busy),    32'(e_busy));
      chk("done_o",    32'(done),    32'(e_done));
      chk("aborted_o", 32'(aborted), 32'(e_ab));
      chk("cal_sel_o", 32'(cal_sel), 32'(e_sel));
      chk("ram_we_o",  32'(we),      32'(e_we));
      if (e_we) begin
        chk("ram_adr_o", 32'(adr), 32'(e_adr));
        chk("ram_dat_o", dat, e_dat);
      end
    end
  end

  typedef struct { logic [RB+1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;
  bit  busy_seen = 0;
  int  g = 0;
  int  mode = 0;

  task automatic tick();
    @(negedge clk);
    if (we)   wlog.push_back('{adr, dat});
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
    g++;
    case (mode)
      1:       valid = 1'b1;
      2:       valid = ((g % 3) == 0);
      default: valid = 1'b0;
    endcase
    data = (mode == 2) ? 32'(32'h1000_0000 + g) : 32'(32'h100 + g);
  endtask

  task automatic launch(input logic [3:0] m, input int ns, input int md, input logic [3:0] dc);
    wlog.delete(); done_cnt = 0; busy_seen = 0; mode = md; g = -1;
    tick();
    start = 1'b1; mask = m; nsamp = 11'(ns); decim = dc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!busy && !done) begin ok = 1; break; end
      tick();
    end
    chk("run_to_idle", 32'(ok), 32'd1);
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_we", 32'(we), 0);
    chk("reset_sel", 32'(cal_sel), 0);
    chk("reset_aborted", 32'(aborted), 0);
    chk_on = 1;

    // Basic two-selection run
    launch(4'b0101, 4, 1, 4'd0);
    run_to_idle(200);
    chk("t1_nwr", wlog.size(), 8);
    chk("t1_adr0", 32'(wlog[0].a), 32'h000);
    chk("t1_dat0", wlog[0].d, 32'h111);
    chk("t1_adr3", 32'(wlog[3].a), 32'h003);
    chk("t1_adr4", 32'(wlog[4].a), 32'h800);
    chk("t1_dat4", wlog[4].d, 32'h126);
    chk("t1_adr7", 32'(wlog[7].a), 32'h803);
    chk("t1_done", done_cnt, 1);

    // Empty runs
    launch(4'b0000, 4, 1, 4'd0);
    chk("t2a_done_now", 32'(done), 1);
    run_to_idle(20);
    chk("t2a_nwr", wlog.size(), 0);
    chk("t2a_busy_seen", 32'(busy_seen), 0);
    launch(4'b1111, 0, 1, 4'd0);
    run_to_idle(20);
    chk("t2b_nwr", wlog.size(), 0);
    chk("t2b_done", done_cnt, 1);
    chk("t2b_busy_seen", 32'(busy_seen), 0);

    // Full region, gapped valids
    launch(4'b1000, 1024, 2, 4'd0);
    run_to_idle(4000);
    chk("t3_nwr", wlog.size(), 1024);
    chk("t3_first", 32'(wlog[0].a), 32'hC00);
    chk("t3_last", 32'(wlog[wlog.size()-1].a), 32'hFFF);
    begin
      int outside = 0;
      foreach (wlog[i]) if (wlog[i].a[RB+1:RB] != 2'd3) outside++;
      chk("t3_outside", outside, 0);
    end

    // Abort after seven writes
    launch(4'b0011, 100, 1, 4'd0);
    for (int i = 0; i < 100; i++) begin
      if (wlog.size() >= 7) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_aborted", 32'(aborted), 1);
    tick(); tick(); tick();
    chk("t4_nwr", wlog.size(), 7);
    chk("t4_adr6", 32'(wlog[6].a), 32'h006);
    chk("t4_done", done_cnt, 0);
    launch(4'b0001, 1, 1, 4'd0);
    chk("t4_clear", 32'(aborted), 0);
    run_to_idle(100);

    // Start while busy is ignored
    launch(4'b0010, 3, 1, 4'd0);
    repeat (5) tick();
    start = 1'b1; mask = 4'b0001; nsamp = 11'd5;
    tick();
    start = 1'b0;
    run_to_idle(200);
    chk("t5_nwr", wlog.size(), 3);
    chk("t5_adr0", 32'(wlog[0].a), 32'h400);
    chk("t5_adr2", 32'(wlog[2].a), 32'h402);
    chk("t5_done", done_cnt, 1);

    // Start with abort in IDLE: abort wins, nothing happens
    wlog.delete(); done_cnt = 0; busy_seen = 0;
    tick();
    start = 1'b1; abort = 1'b1; mask = 4'b0001; nsamp = 11'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("t5b_busy_seen", 32'(busy_seen), 0);
    chk("t5b_aborted", 32'(aborted), 0);
    chk("t5b_done", done_cnt, 0);

    // Asynchronous reset mid-capture
    launch(4'b0100, 50, 1, 4'd0);
    for (int i = 0; i < 100; i++) begin
      if (wlog.size() >= 3) break;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_we", 32'(we), 0);
    chk("t6_sel", 32'(cal_sel), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_nwr", wlog.size(), 3);
    chk("t6_idle", 32'(busy), 0);

`ifdef ADC_CAPTURE_SEQ_DECIM_EN
    launch(4'b0001, 3, 1, 4'd2);
    run_to_idle(200);
    chk("t7_nwr", wlog.size(), 3);
    chk("t7_dat0", wlog[0].d, 32'h111);
    chk("t7_dat1", wlog[1].d, 32'h114);
    chk("t7_dat2", wlog[2].d, 32'h117);
    chk("t7_adr2", 32'(wlog[2].a), 32'h002);
`endif

    mode = 0;
    tick();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
